// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Define BIN2BCD_OVF_EN to build the overflow accumulator; otherwise ovf is tied low.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     work_q, work_d;
  logic [WIDTH-1:0]  oper_q, oper_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     adj_c;
  logic [BW-1:0]     work_shift_c;

`ifdef BIN2BCD_OVF_EN
  logic acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic out_bit_c;
`endif

  // Add-3 correction on every digit, all evaluated from pre-shift values
  always_comb begin
    adj_c = work_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (work_q[4*d +: 4] >= 4'd5) begin
        adj_c[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
      end
    end
  end

  assign work_shift_c = {adj_c[BW-2:0], oper_q[WIDTH-1]};
`ifdef BIN2BCD_OVF_EN
  assign out_bit_c = adj_c[BW-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      oper_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_OVF_EN
      acc_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      oper_q  <= oper_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BIN2BCD_OVF_EN
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    oper_d  = oper_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef BIN2BCD_OVF_EN
    acc_d   = acc_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          oper_d  = bin_in;
          work_d  = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BIN2BCD_OVF_EN
          acc_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        work_d = work_shift_c;
        oper_d = oper_q << 1;
        cnt_d  = cnt_q - CW'(1);
`ifdef BIN2BCD_OVF_EN
        acc_d  = acc_q | out_bit_c;
`endif
        if (cnt_q == CW'(1)) begin
          bcd_d   = work_shift_c;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BIN2BCD_OVF_EN
          ovf_d   = acc_q | out_bit_c;
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
`ifdef BIN2BCD_OVF_EN
  assign ovf     = ovf_q;
`else
  assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a 2-digit and a 1-digit instance.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [5:0] bin_a = '0, bin_b = '0;
  logic       busy_a, done_a, ovf_a;
  logic [7:0] bcd_a;
  logic       busy_b, done_b, ovf_b;
  logic [3:0] bcd_b;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(6), .DIGITS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.WIDTH(6), .DIGITS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and wait (bounded) for done; lat=-1 on timeout
  task automatic run_conv(input bit sel, input logic [5:0] v, output int lat,
                          output logic [7:0] res, output logic ov);
    if (sel) begin start_b = 1'b1; bin_b = v; end
    else     begin start_a = 1'b1; bin_a = v; end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      if (sel ? done_b : done_a) begin
        lat = i;
        break;
      end
    end
    res = sel ? {4'h0, bcd_b} : bcd_a;
    ov  = sel ? ovf_b : ovf_a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
    total++; if (bcd_a !== 8'h00)  begin bad++; $display("FAIL reset_bcd got=%h exp=00", bcd_a); end
    total++; if (ovf_a !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    total++; if (bcd_b !== 4'h0)   begin bad++; $display("FAIL reset_bcd1 got=%h exp=0", bcd_b); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_max();
    int lat;
    lat = -1;
    start_a = 1'b1;
    bin_a   = 6'd63;
    for (int i = 1; i <= 12; i++) begin
      tick();
      start_a = 1'b0;
      total++;
      if (busy_a && done_a) begin bad++; $display("FAIL max_overlap cyc=%0d busy=1 done=1 exp not both", i); end
      if (done_a) begin lat = i; break; end
      total++;
      if (busy_a !== 1'b1) begin bad++; $display("FAIL max_busy cyc=%0d got=%b exp=1", i, busy_a); end
    end
    total++; if (lat != 7)         begin bad++; $display("FAIL max_latency got=%0d exp=7", lat); end
    total++; if (bcd_a !== 8'h63)  begin bad++; $display("FAIL max_bcd got=%h exp=63", bcd_a); end
    total++; if (ovf_a !== 1'b0)   begin bad++; $display("FAIL max_ovf got=%b exp=0", ovf_a); end
    tick();
    total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL max_done_pulse got=%b exp=0", done_a); end
  endtask

  task automatic test_boundaries();
    logic [5:0] vin [4] = '{6'd0, 6'd9, 6'd10, 6'd59};
    logic [7:0] vexp[4] = '{8'h00, 8'h09, 8'h10, 8'h59};
    int lat;
    logic [7:0] res;
    logic ov;
    for (int k = 0; k < 4; k++) begin
      run_conv(1'b0, vin[k], lat, res, ov);
      total++; if (lat != 7)        begin bad++; $display("FAIL bnd_latency in=%0d got=%0d exp=7", vin[k], lat); end
      total++; if (res !== vexp[k]) begin bad++; $display("FAIL bnd_bcd in=%0d got=%h exp=%h", vin[k], res, vexp[k]); end
      total++; if (ov !== 1'b0)     begin bad++; $display("FAIL bnd_ovf in=%0d got=%b exp=0", vin[k], ov); end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, gap;
    bit held_ok;
    lat1 = -1; gap = -1; held_ok = 1'b1;
    start_a = 1'b1;
    bin_a   = 6'd12;
    for (int i = 1; i <= 20; i++) begin
      tick();
      bin_a = 6'd45;
      if (done_a) begin lat1 = i; break; end
    end
    total++; if (lat1 != 7)        begin bad++; $display("FAIL b2b_lat1 got=%0d exp=7", lat1); end
    total++; if (bcd_a !== 8'h12)  begin bad++; $display("FAIL b2b_first got=%h exp=12", bcd_a); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done_a) begin gap = i; start_a = 1'b0; break; end
      if (bcd_a !== 8'h12) held_ok = 1'b0;
    end
    start_a = 1'b0;
    total++; if (gap != 7)         begin bad++; $display("FAIL b2b_gap got=%0d exp=7", gap); end
    total++; if (bcd_a !== 8'h45)  begin bad++; $display("FAIL b2b_second got=%h exp=45", bcd_a); end
    total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%b exp=1", held_ok); end
    tick();
  endtask

  task automatic test_start_busy();
    int ndone, extra;
    ndone = 0; extra = 0;
    start_a = 1'b1;
    bin_a   = 6'd21;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    start_a = 1'b1;
    bin_a   = 6'd7;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done_a) begin
        ndone++;
        if (ndone == 1) begin
          total++; if (bcd_a !== 8'h21) begin bad++; $display("FAIL busy_bcd got=%h exp=21", bcd_a); end
        end
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      if (done_a) extra++;
      tick();
    end
    total++; if (ndone != 1)       begin bad++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
    total++; if (extra != 0)       begin bad++; $display("FAIL busy_queued got=%0d exp=0", extra); end
    total++; if (bcd_a !== 8'h21)  begin bad++; $display("FAIL busy_final got=%h exp=21", bcd_a); end
    total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL busy_idle got=%b exp=0", busy_a); end
  endtask

  task automatic test_reset_mid();
    int ndone, lat;
    logic [7:0] res;
    logic ov;
    ndone = 0;
    start_a = 1'b1;
    bin_a   = 6'd50;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL rstmid_done got=%b exp=0", done_a); end
    total++; if (bcd_a !== 8'h00)  begin bad++; $display("FAIL rstmid_bcd got=%h exp=00", bcd_a); end
    for (int i = 0; i < 12; i++) begin
      if (done_a) ndone++;
      tick();
    end
    total++; if (ndone != 0)       begin bad++; $display("FAIL rstmid_spurious got=%0d exp=0", ndone); end
    run_conv(1'b0, 6'd50, lat, res, ov);
    total++; if (lat != 7)         begin bad++; $display("FAIL rstmid_latency got=%0d exp=7", lat); end
    total++; if (res !== 8'h50)    begin bad++; $display("FAIL rstmid_bcd50 got=%h exp=50", res); end
  endtask

  task automatic test_one_digit();
    int lat;
    logic [7:0] res;
    logic ov;
    run_conv(1'b1, 6'd42, lat, res, ov);
    total++; if (lat != 7)         begin bad++; $display("FAIL d1_latency got=%0d exp=7", lat); end
    total++; if (res !== 8'h02)    begin bad++; $display("FAIL d1_bcd42 got=%h exp=02", res); end
    total++; if (ov !== OVF_EN)    begin bad++; $display("FAIL d1_ovf42 got=%b exp=%b", ov, OVF_EN); end
    tick();
    run_conv(1'b1, 6'd9, lat, res, ov);
    total++; if (res !== 8'h09)    begin bad++; $display("FAIL d1_bcd9 got=%h exp=09", res); end
    total++; if (ov !== 1'b0)      begin bad++; $display("FAIL d1_ovf9 got=%b exp=0", ov); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_boundaries();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_one_digit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) algorithm. It accepts a WIDTH-bit unsigned binary value and produces DIGITS packed BCD digits after WIDTH shift cycles. A start/busy/done handshake controls it. It sits between the datapath result register and the seven-segment display drivers, and supersedes per-digit combinational add-3 cell chains.

## Interface
- WIDTH, 6: binary input width in bits (≥ 1).
- DIGITS, 2: number of BCD output digits (≥ 1).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion; sampled only in IDLE.
- bin_in  in  WIDTH  unsigned binary operand; captured on the accepting edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd_out is valid.
- bcd_out  out  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; holds its value until the next done.
- ovf  out  1  result exceeded DIGITS digits; valid with done, held with bcd_out.

## Operation
- States: IDLE and SHIFT.
- IDLE with start=1:
  - Latch bin_in into the shift operand.
  - Clear the BCD working register (4*DIGITS bits).
  - Load the bit counter with WIDTH and clear the overflow accumulator.
  - Go to SHIFT; busy=1.
- SHIFT, each edge:
  - Add 3 to every 4-bit working digit whose value is ≥ 5, evaluating all digits in parallel from pre-shift values.
  - Shift {working, operand} left by 1; operand MSB enters working bit 0.
  - The bit leaving the working MSB is ORed into the overflow accumulator.
  - Decrement the counter.
- Last shift (counter=1):
  - Register the post-shift working value into bcd_out and the accumulator into ovf.
  - done=1 for the next cycle; return to IDLE; busy=0.
- start while busy: ignored, no queuing.
- start is honoured in the cycle done is high, so back-to-back conversions work.
- Digit arithmetic:
  - 4-bit add-3 never exceeds 4 bits, because input ≤ 9 post-shift yields ≤ 12 pre-shift.
  - Working digits are always 0–9 after each shift.
- Truncation: when bin_in ≥ 10^DIGITS, bcd_out equals bin_in mod 10^DIGITS, because the upper digits are dropped.
- Reset, any state including mid-SHIFT:
  - Go to IDLE.
  - busy=0, done=0, bcd_out=0, ovf=0.
  - Working register, operand and counter cleared.
  - The aborted conversion produces no done.

## Timing
- Start accepted at edge E0; shifts at edges E1..E_WIDTH; done high during the cycle after E_WIDTH.
- Latency is WIDTH+1 cycles from the start cycle to the done cycle.
- Throughput is one conversion per WIDTH+1 cycles with start held high.
- busy rises the cycle after E0 and falls together with the rise of done.
- done and busy are never high in the same cycle.
- bcd_out and ovf change only on the edge that raises done, or on reset.

## Configuration
- BIN2BCD_OVF_EN defined:
  - The overflow accumulator is built.
  - ovf reports whether any 1 bit was shifted out of the top digit, i.e. bin_in ≥ 10^DIGITS.
- BIN2BCD_OVF_EN undefined:
  - No accumulator logic is built; ovf is tied to 0.
  - bcd_out truncation behaviour is unchanged.

## Test plan
- WIDTH=6, DIGITS=2, reset then start with bin_in=63 → done exactly 7 cycles after the start cycle; bcd_out=8'h63; ovf=0.
- Directed boundaries, same config: bin_in=0 → 8'h00; 9 → 8'h09; 10 → 8'h10; 59 → 8'h59.
- Back-to-back: start held high with bin_in 12 then 45 → two done pulses 7 cycles apart, results 8'h12 then 8'h45; bcd_out holds 8'h12 between the pulses.
- Start during busy: a start pulse with bin_in=7, 3 cycles into converting 21 → single done with 8'h21; the 7 is never converted.
- Reset mid-conversion: rst for 1 cycle at cycle 4 of converting 50 → no done; busy=0, bcd_out=0 next cycle; a fresh start of 50 → 8'h50.
- DIGITS=1, WIDTH=6, bin_in=42 → bcd_out=4'h2; ovf=1 with BIN2BCD_OVF_EN, 0 without; bin_in=9 → ovf=0 in both builds.
